// File: rtl/result_bcd_converter_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD result converter.
// No logic; pure declarations.
// No flow control; consumed by the converter and its digit adjust cells.
package result_bcd_converter_pkg;

    // Width of one packed BCD digit
    localparam int BCD_DIGIT_W = 4;

    // Digits at or above this value get +3 before each doubling step
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;

    // FSM state encodings
    localparam logic [0:0] STATE_IDLE_ENC  = 1'b0;
    localparam logic [0:0] STATE_SHIFT_ENC = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = STATE_IDLE_ENC,
        SHIFT = STATE_SHIFT_ENC
    } state_t;

endpackage

// File: rtl/result_bcd_converter_digit_adj.sv
// Single BCD digit correction for double-dabble: add 3 when digit >= 5.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_adj
    import result_bcd_converter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    // A digit of 5..9 doubles past 9, so pre-bias it by 3 to carry correctly
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADD3_THRESHOLD) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/result_bcd_converter.sv
// Converts each new adder result to packed BCD with a one-bit-per-clock double-dabble engine.
// Latency: WIDTH cycles from the capture edge to the one-cycle valid pulse.
// Backpressure: none; done_in rising edges seen while busy are dropped, not queued.
module result_bcd_converter
    import result_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          done_in,
    input  logic [WIDTH-1:0]              bin_in,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          valid,
    output logic                          busy
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t                 state;
    logic                   done_prev;
    logic [CNT_W-1:0]       cnt;
    logic [WIDTH-1:0]       bin_sh;
    logic [BCD_W-1:0]       bcd_sh;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+WIDTH-1:0] cat_adj;
    logic [BCD_W+WIDTH-1:0] cat_shifted;
    logic                   start;

    // Only a fresh rising edge of done while idle launches a conversion
    assign start = done_in & ~done_prev & ~busy;

    // Per-digit add-3 correction applied to the scratch BCD register
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (bcd_sh [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected digits and remaining binary shift left together; bin MSB enters BCD LSB
    always_comb begin
        cat_adj     = {bcd_adj, bin_sh};
        cat_shifted = cat_adj << 1;
    end

    // Edge detector, FSM, iteration counter, shift registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done_prev <= 1'b0;
            cnt       <= '0;
            bin_sh    <= '0;
            bcd_sh    <= '0;
            bcd_out   <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Track done every cycle so edges during busy are consumed, not deferred
            done_prev <= done_in;
            valid     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sh <= bin_in;
                        bcd_sh <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_sh <= cat_shifted[BCD_W+WIDTH-1:WIDTH];
                    bin_sh <= cat_shifted[WIDTH-1:0];
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // Final iteration: publish digits directly from the shifted value
                        bcd_out <= cat_shifted[BCD_W+WIDTH-1:WIDTH];
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed self-checking bench for result_bcd_converter at default parameters.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// All waits on valid are bounded by a cycle budget.
module tb_result_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        done_in;
    logic [8:0]  bin_in;
    logic [11:0] bcd_out;
    logic        valid;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    result_bcd_converter #(.WIDTH(9), .DIGITS(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .done_in (done_in),
        .bin_in  (bin_in),
        .bcd_out (bcd_out),
        .valid   (valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the capture edge; measures latency, busy span and result
    task automatic wait_result(input string tag, input logic [11:0] exp);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        while (!valid && lat < 20) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd9);
        check({tag, "_bcd"}, 32'(bcd_out), 32'(exp));
        check({tag, "_busy_at_valid"}, 32'(busy), 32'd0);
        done_in = 1'b0;
        tick();
        check({tag, "_valid_one_cycle"}, 32'(valid), 32'd0);
        check({tag, "_bcd_hold"}, 32'(bcd_out), 32'(exp));
    endtask

    // Raise done with a value (done is low beforehand) and check the conversion
    task automatic convert(input string tag, input logic [8:0] v, input logic [11:0] exp);
        bin_in  = v;
        done_in = 1'b1;
        tick();
        wait_result(tag, exp);
    endtask

    initial begin
        int vcnt;
        rst     = 1'b1;
        done_in = 1'b0;
        bin_in  = '0;
        tick();
        tick();
        check("reset_bcd", 32'(bcd_out), 32'h0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Main function and boundary values
        convert("sum_256", 9'd256, 12'h256);
        convert("zero", 9'd0, 12'h000);
        convert("max_511", 9'd511, 12'h511);
        convert("nine", 9'd9, 12'h009);
        convert("hundred", 9'd100, 12'h100);

        // Held-high done gives exactly one conversion
        bin_in  = 9'd123;
        done_in = 1'b1;
        vcnt    = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (valid) vcnt++;
        end
        check("held_valid_count", 32'(vcnt), 32'd1);
        check("held_bcd", 32'(bcd_out), 32'h123);
        done_in = 1'b0;
        tick();
        convert("held_second_37", 9'd37, 12'h037);

        // Second rising edge while busy is ignored; bin_in change after capture is ignored
        bin_in  = 9'd300;
        done_in = 1'b1;
        tick();
        check("busy_edge_started", 32'(busy), 32'd1);
        done_in = 1'b0;
        tick();
        tick();
        bin_in  = 9'd5;
        done_in = 1'b1;
        vcnt    = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (valid) vcnt++;
        end
        check("busy_edge_valid_count", 32'(vcnt), 32'd1);
        check("busy_edge_bcd", 32'(bcd_out), 32'h300);
        done_in = 1'b0;
        tick();

        // Reset in the middle of a conversion
        bin_in  = 9'd99;
        done_in = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst     = 1'b1;
        done_in = 1'b0;
        tick();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_bcd", 32'(bcd_out), 32'h0);
        rst  = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid) vcnt++;
        end
        check("midrst_no_pulse", 32'(vcnt), 32'd0);
        convert("after_rst_200", 9'd200, 12'h200);

        // done high through reset release starts on the first post-reset edge
        rst     = 1'b1;
        done_in = 1'b1;
        bin_in  = 9'd45;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_release_busy", 32'(busy), 32'd1);
        wait_result("rst_release_45", 12'h045);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_bcd_converter.md
# result_bcd_converter

Downstream stage of the serial adder top. Watches the adder's `done` and `result` outputs. On each new completion it converts the 9-bit binary sum to three packed BCD digits using a sequential shift-and-add-3 (double-dabble) engine, one bit per clock. It then presents the digits with a one-cycle valid strobe for the display or readout stage that follows.

## Interface

Parameters:
- `WIDTH`, default 9: binary input width; matches the adder result (8+8 bit sum with carry).
- `DIGITS`, default 3: number of BCD digits. 10^DIGITS must exceed 2^WIDTH−1.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `done_in` input 1: adder `done`; level signal that may stay high indefinitely.
- `bin_in` input WIDTH: adder `result`; sampled only on the capture edge.
- `bcd_out` output 4·DIGITS: packed BCD, digit 0 in [3:0] (units), digit 2 in [11:8] (hundreds).
- `valid` output 1: one-cycle pulse when `bcd_out` has just been updated.
- `busy` output 1: high while a conversion is in progress.

## Operation

- Start detection:
  - `done_prev` registers `done_in` every cycle.
  - A start is `done_in & ~done_prev & ~busy`.
  - A start occurs only on a rising edge of `done_in`. A held-high `done_in` produces exactly one conversion.
- FSM states: IDLE, SHIFT.
- IDLE:
  - On start, latch `bin_in` into shift register `bin_sh` and clear scratch register `bcd_sh`.
  - Set `cnt` = 0 and go to SHIFT.
- SHIFT, one iteration per cycle:
  - Each digit of `bcd_sh` that is ≥5 gets +3 (4-bit, no overflow possible).
  - Then shift left by one the concatenation {`bcd_sh`, `bin_sh`}; the MSB of `bin_sh` enters the LSB of `bcd_sh`.
  - `cnt` increments each iteration.
  - On the iteration with `cnt` == WIDTH−1, load the shifted result into `bcd_out`, pulse `valid`, and return to IDLE.
- `cnt` width is clog2(WIDTH); it never wraps within a conversion.
- `bcd_out` holds its last value until the next conversion completes. It never shows intermediate values.
- Rising edges of `done_in` while `busy` = 1 are ignored, not queued.
  - `done_prev` still tracks them, so an edge that arrives during busy does not start a conversion after busy clears.
- `bin_in` changes after the capture edge have no effect.
- Reset, including mid-conversion:
  - FSM returns to IDLE.
  - `bcd_out` = 0, `valid` = 0, `busy` = 0.
  - `done_prev` = 0, `cnt` = 0, scratch registers = 0.
  - If `done_in` is high when reset releases, that counts as a rising edge and starts a conversion on the first post-reset edge.

## Timing

- Edge E0 samples the start condition and performs the capture. `busy` is high from the cycle after E0.
- Edges E1..E_WIDTH perform the WIDTH shift iterations.
- `bcd_out` and `valid` update at E_WIDTH. `valid` is high for exactly one cycle.
- `busy` falls at E_WIDTH, in the same cycle that `valid` rises.
- Latency from the capture edge to `valid` is WIDTH cycles: 9 at the defaults.
- Throughput: a new start is accepted at E_WIDTH+1 at the earliest, i.e. the cycle after `valid`.
- `valid` and `busy` are never both high.

## Structure

- Shared package/include holds:
  - FSM state localparams (IDLE = 0, SHIFT = 1).
  - BCD digit width constant (4).
  - Add-3 threshold constant (5).
- Sub-module `bcd_digit_adj`:
  - Combinational, 4-bit in/out.
  - Output = in + 3 if in ≥ 5, else in.
  - Instantiated DIGITS times with a generate loop.
- Top holds the FSM, counter, edge detector, shift registers and output register.

## Test plan

- **128+128:** `bin_in` = 256 with `done_in` rising → after 9 cycles, `valid` pulses once and `bcd_out` = 0x256. `busy` is high for the 9 cycles in between.
- **Boundary values:** `bin_in` = 0 gives 0x000; 511 gives 0x511; 9 gives 0x009; 100 gives 0x100. Each arrives with exact 9-cycle latency.
- **Held done:** `done_in` held high for 50 cycles → exactly one `valid` pulse. Dropping `done_in` and raising it again with `bin_in` = 37 gives a second pulse with `bcd_out` = 0x037.
- **Edge while busy:** a second rising edge with `bin_in` = 5, arriving 3 cycles after the first capture → ignored. `bcd_out` reflects only the first value, and no second `valid` occurs.
- **Reset mid-conversion:** `rst` asserted at iteration 4 → next cycle `busy` = 0, `valid` = 0, `bcd_out` = 0, and no pulse follows. A subsequent start with 200 gives 0x200.
- **Reset release with done high:** `done_in` = 1 during and after reset → one conversion starts on the first post-reset edge, and `valid` arrives 9 cycles later.
